// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle: ID/EX hazard info, memory handshake, pipeline controls
interface pipeline_hazard_ctrl_if;
  logic [31:0] id_instr_i;
  logic        ex_memread_i;
  logic        ex_regwrite_i;
  logic [4:0]  ex_rd_i;
  logic        id_branch_taken_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic        pc_write_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        id_ex_bubble_o;
  logic        pipe_freeze_o;
  logic        mem_timeout_o;

  modport master (
    output id_instr_i, ex_memread_i, ex_regwrite_i, ex_rd_i, id_branch_taken_i,
    output mem_req_i, mem_ack_i,
    input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
    input  pipe_freeze_o, mem_timeout_o
  );

  modport slave (
    input  id_instr_i, ex_memread_i, ex_regwrite_i, ex_rd_i, id_branch_taken_i,
    input  mem_req_i, mem_ack_i,
    output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
    output pipe_freeze_o, mem_timeout_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/freeze sequencer for a 5-stage pipeline; optional perf counters via HAZARD_PERF_CNT_EN
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipeline_hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      freeze_cnt_o
`endif
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] L_WAIT_MAX = WCW'(MEM_TIMEOUT);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_stall_cnt;
  logic [1:0]     w_stall_cnt_nxt;
  logic [WCW-1:0] r_wait_cnt;
  logic           r_timeout;

  logic [6:0] w_opcode;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic       w_is_branch;
  logic       w_match;
  logic       w_lu;
  logic       w_bra;

  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_bubble;
  logic w_freeze;

  assign w_opcode    = bus.id_instr_i[6:0];
  assign w_rs1       = bus.id_instr_i[19:15];
  assign w_rs2       = bus.id_instr_i[24:20];
  assign w_is_branch = (w_opcode == 7'b1100011);

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (w_opcode)
      7'b0110011, 7'b0100011, 7'b1100011: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011: w_use_rs1 = 1'b1;
      default: ;
    endcase
  end

  // x0 is hardwired zero, so a write to it can never feed a consumer
  assign w_match = (bus.ex_rd_i != 5'd0) &&
                   ((w_use_rs1 && (w_rs1 == bus.ex_rd_i)) ||
                    (w_use_rs2 && (w_rs2 == bus.ex_rd_i)));

  assign w_lu  = bus.ex_memread_i && w_match;
  assign w_bra = w_is_branch && bus.ex_regwrite_i && !bus.ex_memread_i && w_match;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_freeze        = 1'b0;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_bubble        = 1'b0;
    if (rst_i) begin
      w_state_nxt     = ST_RUN;
      w_stall_cnt_nxt = 2'd0;
      w_pc_write      = 1'b0;
      w_if_id_write   = 1'b0;
      w_bubble        = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.mem_req_i && !bus.mem_ack_i) begin
            w_freeze    = 1'b1;
            w_state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack_i) w_state_nxt = ST_RUN;
          else               w_freeze    = 1'b1;
        end
        default: w_state_nxt = ST_RUN;
      endcase

      // freeze outranks stall, stall outranks flush; a taken branch seen while stalled is dropped
      if (w_freeze) begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
      end else if (r_stall_cnt != 2'd0 || w_lu || w_bra) begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_bubble      = 1'b1;
        if (r_stall_cnt != 2'd0)       w_stall_cnt_nxt = r_stall_cnt - 2'd1;
        else if (w_lu && w_is_branch)  w_stall_cnt_nxt = 2'd1;
      end else if (w_is_branch && bus.id_branch_taken_i) begin
        w_if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (r_wait_cnt == L_WAIT_MAX) r_timeout <= 1'b1;
      if (!w_freeze)                     r_wait_cnt <= '0;
      else if (r_wait_cnt != L_WAIT_MAX) r_wait_cnt <= r_wait_cnt + WCW'(1);
    end
  end

  assign bus.pc_write_o     = w_pc_write;
  assign bus.if_id_write_o  = w_if_id_write;
  assign bus.if_id_flush_o  = w_if_id_flush;
  assign bus.id_ex_bubble_o = w_bubble;
  assign bus.pipe_freeze_o  = w_freeze;
  assign bus.mem_timeout_o  = r_timeout && !rst_i;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_pc;
  logic [CNT_W-1:0] r_flush_pc;
  logic [CNT_W-1:0] r_freeze_pc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_pc  <= '0;
      r_flush_pc  <= '0;
      r_freeze_pc <= '0;
    end else begin
      if (w_bubble)      r_stall_pc  <= r_stall_pc + CNT_W'(1);
      if (w_if_id_flush) r_flush_pc  <= r_flush_pc + CNT_W'(1);
      if (w_freeze)      r_freeze_pc <= r_freeze_pc + CNT_W'(1);
    end
  end

  assign stall_cnt_o  = r_stall_pc;
  assign flush_cnt_o  = r_flush_pc;
  assign freeze_cnt_o = r_freeze_pc;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). Branches resolve in ID.
- Detects load-use and branch-operand hazards from the ID instruction word and EX-stage destination info.
- Handles branch-taken flushes.
- Freezes the whole pipeline while the data memory handshake is pending.
- Drives PC/IF-ID write enables, IF-ID flush, ID-EX bubble and the global freeze.

Parameters:
MEM_TIMEOUT, 64, consecutive freeze cycles after which mem_timeout_o is raised (min 2).
CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous, active-high reset.
id_instr_i  in  32  instruction word in ID.
ex_memread_i  in  1  EX instruction is a load.
ex_regwrite_i  in  1  EX instruction writes rd.
ex_rd_i  in  5  EX destination register.
id_branch_taken_i  in  1  ID-stage branch compare result; valid only when ID opcode is 1100011.
mem_req_i  in  1  MEM stage issues a load/store this cycle.
mem_ack_i  in  1  data memory completes the access; may arrive in the same cycle as the request.
pc_write_o  out  1  PC update enable.
if_id_write_o  out  1  IF/ID register write enable.
if_id_flush_o  out  1  IF/ID register loads a NOP.
id_ex_bubble_o  out  1  ID/EX register loads control-zero bubble.
pipe_freeze_o  out  1  hold all pipeline registers (EX/MEM/WB included).
mem_timeout_o  out  1  sticky memory-timeout error.

Behaviour:
ID decode, opcode = id_instr_i[6:0]:
- rs1 is used for 0110011, 0010011, 0000011, 0100011, 1100011.
- rs2 is used only for 0110011, 0100011, 1100011.
- Other opcodes use no source registers.
- A register equal to x0 never creates a hazard.

Hazard matches (m = a used rs1/rs2 equals ex_rd_i, ex_rd_i != 0):
- LU: ex_memread_i && m.
- BRA: ID is a branch && ex_regwrite_i && !ex_memread_i && m.

Registered state: fsm {RUN, WAIT}, stall_cnt[1:0], wait_cnt, timeout flag.

Memory FSM:
- RUN -> WAIT when mem_req_i && !mem_ack_i.
- WAIT -> RUN when mem_ack_i.
- pipe_freeze_o = (RUN && mem_req_i && !mem_ack_i) || (WAIT && !mem_ack_i). Combinational, zero latency.
- The freeze drops in the ack cycle.

Stall sequencing (evaluated only when pipe_freeze_o = 0):
- stall_cnt != 0: stall cycle; stall_cnt decrements.
- else LU with branch in ID: stall; stall_cnt <= 1 (2 bubbles total, load must reach MEM/WB).
- else LU or BRA: stall; 1 bubble.
- else branch taken: if_id_flush_o = 1 for 1 cycle.
- A stall cycle drives pc_write_o = 0, if_id_write_o = 0, id_ex_bubble_o = 1, if_id_flush_o = 0.
- Normal cycle: pc_write_o = 1, if_id_write_o = 1, others 0.

Priority and boundary cases:
- Freeze > stall > flush.
- During freeze: pc_write_o = 0, if_id_write_o = 0, bubble = 0, flush = 0. stall_cnt holds; the pending bubble is re-evaluated after the freeze.
- Branch taken while stalled is ignored; the branch is re-evaluated with fresh operands.

Timeout:
- wait_cnt counts consecutive freeze cycles and clears when the freeze drops.
- When it reaches MEM_TIMEOUT, mem_timeout_o sets in the next cycle and stays set until reset.
- The freeze continues while the timeout is set.

Reset (rst_i = 1, including mid-WAIT):
- Next state RUN, stall_cnt 0, wait_cnt 0, mem_timeout_o 0.
- A pending ack is discarded.
- Outputs while rst_i is high: pc_write_o = 0, if_id_write_o = 0, if_id_flush_o = 0, id_ex_bubble_o = 1, pipe_freeze_o = 0, mem_timeout_o = 0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds output ports stall_cnt_o[CNT_W-1:0], flush_cnt_o[CNT_W-1:0] and freeze_cnt_o[CNT_W-1:0].
- Each counter increments once per stall, flush or freeze cycle respectively, wraps at 2^CNT_W, and resets to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Load-use: ex_memread_i=1, ex_rd_i=5, id_instr_i=0x00228333 (add x6,x5,x2) -> 1 cycle with pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; next cycle (EX cleared) all normal.
2. Load then branch: ex_memread_i=1, ex_rd_i=5, id_instr_i=0x00028063 (beq x5,x0), id_branch_taken_i=1 throughout -> exactly 2 stall cycles, no flush during them; 3rd cycle if_id_flush_o=1.
3. x0 / unused rs2: ex_memread_i=1, ex_rd_i=0, any ID -> no stall. ex_rd_i=2, id_instr_i=0x00500393 (addi x7,x0,5) -> no stall.
4. Memory wait: mem_req_i=1 at cycle 0, mem_ack_i=1 at cycle 3 -> pipe_freeze_o=1 cycles 0-2, 0 at cycle 3. Same-cycle ack -> no freeze.
5. Freeze with pending load-use: LU present and mem_req_i held for 4 cycles -> bubble=0 during the freeze; a single bubble follows the ack.
6. Timeout/reset: MEM_TIMEOUT=4, no ack -> mem_timeout_o=1 from cycle 5, sticky. rst_i=1 in WAIT -> next cycle freeze=0, timeout=0, fsm RUN.
